// File: rtl/controle_vedacao.sv
// Sealing-station controller: stops the conveyor for an arriving bottle, requests one cork,
// waits for the dispenser acknowledge, holds for the capping time and tracks magazine stock.
module controle_vedacao #(
  parameter int MAX_ROLHAS = 20,
  parameter int W          = 5,
  parameter int T_ACK      = 8,
  parameter int T_VEDA     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sensor_garrafa,
  input  logic         disp,
  input  logic         add_rolha,
  output logic         rolha5,
  output logic         esteira,
  output logic         vedado,
  output logic [W-1:0] estoque,
  output logic         vazio,
  output logic         cheio,
  output logic         alarme
);

  localparam int AW = (T_ACK  > 1) ? $clog2(T_ACK  + 1) : 1;
  localparam int VW = (T_VEDA > 1) ? $clog2(T_VEDA + 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEM_ROLHA = 3'd1,
    SOLICITA  = 3'd2,
    ESPERA    = 3'd3,
    VEDA      = 3'd4,
    LIBERA    = 3'd5,
    ERRO      = 3'd6
  } state_t;

  state_t          state;
  logic            sens_q;
  logic            chegada;
  logic [AW-1:0]   ack_timer;
  logic [VW-1:0]   veda_timer;

  assign chegada = sensor_garrafa & ~sens_q;
  assign vazio   = (estoque == W'(0));
  assign cheio   = (estoque == W'(MAX_ROLHAS));

  // Registered copy of the bottle sensor for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sens_q <= 1'b0;
    end else begin
      sens_q <= sensor_garrafa;
    end
  end

  // Magazine stock: saturates at both ends, simultaneous add and dispense cancel out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estoque <= W'(0);
    end else if (add_rolha && !disp) begin
      if (estoque < W'(MAX_ROLHAS)) begin
        estoque <= estoque + W'(1);
      end
    end else if (disp && !add_rolha) begin
      if (estoque != W'(0)) begin
        estoque <= estoque - W'(1);
      end
    end
  end

  // Station sequencer with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rolha5     <= 1'b0;
      vedado     <= 1'b0;
      esteira    <= 1'b1;
      alarme     <= 1'b0;
      ack_timer  <= AW'(0);
      veda_timer <= VW'(0);
    end else begin
      rolha5 <= 1'b0;
      vedado <= 1'b0;
      case (state)
        IDLE: begin
          esteira <= 1'b1;
          alarme  <= 1'b0;
          if (chegada) begin
            esteira <= 1'b0;
            if (estoque != W'(0)) begin
              state  <= SOLICITA;
              rolha5 <= 1'b1;
            end else begin
              state  <= SEM_ROLHA;
              alarme <= 1'b1;
            end
          end
        end
        SEM_ROLHA: begin
          esteira <= 1'b0;
          if (estoque != W'(0)) begin
            state  <= SOLICITA;
            rolha5 <= 1'b1;
            alarme <= 1'b0;
          end
        end
        SOLICITA: begin
          esteira   <= 1'b0;
          ack_timer <= AW'(0);
          state     <= ESPERA;
        end
        ESPERA: begin
          esteira <= 1'b0;
          // an acknowledge in the expiry cycle still wins over the timeout
          if (disp) begin
            veda_timer <= VW'(0);
            state      <= VEDA;
          end else if (ack_timer == AW'(T_ACK - 1)) begin
            state  <= ERRO;
            alarme <= 1'b1;
          end else begin
            ack_timer <= ack_timer + AW'(1);
          end
        end
        VEDA: begin
          if (veda_timer == VW'(T_VEDA - 1)) begin
            state   <= LIBERA;
            vedado  <= 1'b1;
            esteira <= 1'b1;
          end else begin
            veda_timer <= veda_timer + VW'(1);
            esteira    <= 1'b0;
          end
        end
        LIBERA: begin
          esteira <= 1'b1;
          if (!sensor_garrafa) begin
            state <= IDLE;
          end
        end
        ERRO: begin
          esteira <= 1'b0;
          alarme  <= 1'b1;
        end
        default: begin
          state   <= ERRO;
          esteira <= 1'b0;
          alarme  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_vedacao.sv
// Directed-plus-random bench for controle_vedacao with a stock model and timing expectations
// derived from the station's acknowledge and capping windows.
module tb_controle_vedacao;

  localparam int MAX    = 20;
  localparam int T_ACK  = 8;
  localparam int T_VEDA = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_garrafa;
  logic       disp;
  logic       add_rolha;
  logic       rolha5;
  logic       esteira;
  logic       vedado;
  logic [4:0] estoque;
  logic       vazio;
  logic       cheio;
  logic       alarme;

  int checks    = 0;
  int failures  = 0;
  int exp_stock = 0;

  controle_vedacao #(.MAX_ROLHAS(MAX), .W(5), .T_ACK(T_ACK), .T_VEDA(T_VEDA)) dut (
    .clk(clk), .reset(reset), .sensor_garrafa(sensor_garrafa), .disp(disp),
    .add_rolha(add_rolha), .rolha5(rolha5), .esteira(esteira), .vedado(vedado),
    .estoque(estoque), .vazio(vazio), .cheio(cheio), .alarme(alarme)
  );

  always #5 clk = ~clk;

  function automatic int stock_after(input int s, input bit a, input bit d);
    if (a && !d) return (s < MAX) ? s + 1 : s;
    if (d && !a) return (s > 0) ? s - 1 : s;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: update the stock model from the inputs seen at the edge, then check stock flags
  task automatic step();
    exp_stock = stock_after(exp_stock, add_rolha, disp);
    @(posedge clk);
    #1;
    chk("estoque", estoque, exp_stock);
    chk("vazio", vazio, exp_stock == 0);
    chk("cheio", cheio, exp_stock == MAX);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sensor_garrafa = 1'b0;
    disp = 1'b0;
    add_rolha = 1'b0;
    exp_stock = 0;
    @(posedge clk);
    #1;
    chk("rst_esteira", esteira, 1);
    chk("rst_rolha5", rolha5, 0);
    chk("rst_vedado", vedado, 0);
    chk("rst_estoque", estoque, 0);
    chk("rst_alarme", alarme, 0);
    reset = 1'b0;
  endtask

  task automatic refill(input int n);
    for (int i = 0; i < n; i++) begin
      add_rolha = 1'b1;
      step();
    end
    add_rolha = 1'b0;
  endtask

  // full bottle cycle; j = idle ESPERA cycles before disp, drop = bottle removed mid-sequence
  task automatic run_bottle(input int j, input bit drop);
    sensor_garrafa = 1'b1;
    step();
    chk("req_rolha5", rolha5, 1);
    chk("req_esteira", esteira, 0);
    chk("req_alarme", alarme, 0);
    step();
    chk("wait_rolha5", rolha5, 0);
    chk("wait_esteira", esteira, 0);
    if (drop) sensor_garrafa = 1'b0;
    for (int i = 0; i < j; i++) begin
      step();
      chk("wait_alarme", alarme, 0);
      chk("wait_rolha5b", rolha5, 0);
      chk("wait_esteira2", esteira, 0);
    end
    disp = 1'b1;
    step();
    disp = 1'b0;
    chk("ack_alarme", alarme, 0);
    for (int i = 1; i < T_VEDA; i++) begin
      step();
      chk("veda_vedado", vedado, 0);
      chk("veda_esteira", esteira, 0);
    end
    step();
    chk("lib_vedado", vedado, 1);
    chk("lib_esteira", esteira, 1);
    if (sensor_garrafa) begin
      step();
      chk("lib_hold_vedado", vedado, 0);
      chk("lib_hold_esteira", esteira, 1);
      chk("lib_hold_rolha5", rolha5, 0);
      sensor_garrafa = 1'b0;
    end
    step();
    chk("idle_esteira", esteira, 1);
    chk("idle_vedado", vedado, 0);
  endtask

  initial begin
    int w;
    // reset and refill
    do_reset();
    refill(3);
    chk("refill3", estoque, 3);
    refill(19);
    chk("refill_sat", estoque, MAX);
    chk("refill_cheio", cheio, 1);

    // random add/disp stream with the conveyor idle
    for (int i = 0; i < 80; i++) begin
      if (i < 40) begin
        add_rolha = ($urandom_range(0, 3) != 0);
        disp      = ($urandom_range(0, 3) == 0);
      end else begin
        add_rolha = ($urandom_range(0, 3) == 0);
        disp      = ($urandom_range(0, 3) != 0);
      end
      step();
      chk("stream_esteira", esteira, 1);
    end
    add_rolha = 1'b0;
    disp = 1'b0;

    // normal bottles from stock 3, then randomized bottles
    do_reset();
    refill(3);
    run_bottle(1, 1'b0);
    chk("bottle_stock", estoque, 2);
    for (int k = 0; k < 6; k++) begin
      if (exp_stock == 0) refill(1 + $urandom_range(0, 2));
      run_bottle($urandom_range(0, T_ACK - 1), 1'($urandom_range(0, 1)));
    end

    // empty magazine: alarm until a cork is added
    do_reset();
    sensor_garrafa = 1'b1;
    step();
    chk("empty_alarme", alarme, 1);
    chk("empty_esteira", esteira, 0);
    chk("empty_rolha5", rolha5, 0);
    w = $urandom_range(1, 5);
    for (int i = 0; i < w; i++) begin
      step();
      chk("empty_hold_rolha5", rolha5, 0);
      chk("empty_hold_alarme", alarme, 1);
    end
    add_rolha = 1'b1;
    step();
    add_rolha = 1'b0;
    chk("empty_add_alarme", alarme, 1);
    chk("empty_add_rolha5", rolha5, 0);
    step();
    chk("empty_req_rolha5", rolha5, 1);
    chk("empty_req_alarme", alarme, 0);

    // timeout: no acknowledge -> sticky error
    do_reset();
    refill(1);
    sensor_garrafa = 1'b1;
    step();
    step();
    for (int i = 0; i < T_ACK - 1; i++) begin
      step();
      chk("to_pre_alarme", alarme, 0);
    end
    step();
    chk("to_alarme", alarme, 1);
    chk("to_esteira", esteira, 0);
    for (int i = 0; i < 10; i++) begin
      sensor_garrafa = 1'($urandom_range(0, 1));
      disp = 1'($urandom_range(0, 1));
      add_rolha = 1'($urandom_range(0, 1));
      step();
      chk("err_alarme", alarme, 1);
      chk("err_esteira", esteira, 0);
      chk("err_rolha5", rolha5, 0);
    end

    // acknowledge in the expiry cycle wins
    do_reset();
    refill(2);
    run_bottle(T_ACK - 1, 1'b0);
    chk("expiry_stock", estoque, 1);

    // simultaneous add and disp, disp at empty
    do_reset();
    refill(5);
    add_rolha = 1'b1;
    disp = 1'b1;
    step();
    chk("both_stock", estoque, 5);
    do_reset();
    add_rolha = 1'b0;
    disp = 1'b1;
    step();
    disp = 1'b0;
    chk("disp_empty", estoque, 0);

    // reset mid-VEDA
    do_reset();
    refill(4);
    sensor_garrafa = 1'b1;
    step();
    step();
    disp = 1'b1;
    step();
    disp = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("midrst_esteira", esteira, 1);
    chk("midrst_rolha5", rolha5, 0);
    chk("midrst_estoque", estoque, 0);
    chk("midrst_vedado", vedado, 0);
    exp_stock = 0;
    sensor_garrafa = 1'b0;
    #2;
    reset = 1'b0;
    step();
    chk("midrst_idle_esteira", esteira, 1);
    chk("midrst_idle_alarme", alarme, 0);
    refill(1);
    sensor_garrafa = 1'b1;
    step();
    chk("midrst_req_rolha5", rolha5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
